sram_stage_sequencer: RTL and testbench
=======================================

SRAM_STAGE_SEQUENCER -- requirements
Module: sram_stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3; number of SRAM client stages, range 1-8.
REQ-002 SHALL have parameter ADDR_W, default 18; SRAM address width.
REQ-003 SHALL have parameter DATA_W, default 16; SRAM data width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 50000000; watchdog limit per stage, 26-bit counter.
REQ-005 Clock_50  in  1  single clock; all state on rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 Trigger  in  1  sequence request, sampled only in S_IDLE.
REQ-008 Stage_mask  in  NUM_STAGES  enabled stages, latched on accepted Trigger.
REQ-009 Stage_start  out  NUM_STAGES  one-hot level start, held high while stage owns SRAM.
REQ-010 Stage_finished  in  NUM_STAGES  stage completion flags.
REQ-011 Stage_address  in  NUM_STAGES*ADDR_W  flattened; stage i at bits [i*ADDR_W +: ADDR_W].
REQ-012 Stage_write_data  in  NUM_STAGES*DATA_W  flattened, same packing as Stage_address.
REQ-013 Stage_we_n  in  NUM_STAGES  per-stage write enable, active low.
REQ-014 Idle_address  in  ADDR_W  display-fetch address, used when no stage is active.
REQ-015 SRAM_address / SRAM_write_data / SRAM_we_n  out  ADDR_W / DATA_W / 1  muxed SRAM bus.
REQ-016 Idle_enable  out  1  display-fetch enable; Busy  out  1; Active_stage  out  3; Done  out  1; Timeout_error  out  1.

Function
REQ-017 States SHALL be S_IDLE, S_RUN, S_GAP, S_DONE.
REQ-018 In S_IDLE, Trigger=1 with Stage_mask!=0 SHALL latch the mask, select the lowest enabled index, and enter S_RUN next cycle; Trigger with mask=0 SHALL be ignored.
REQ-019 Stage_start[Active_stage] SHALL be 1 in every S_RUN cycle; all other bits SHALL be 0.
REQ-020 In S_RUN, Stage_finished[Active_stage]=1 SHALL clear that latched mask bit and enter S_GAP; the flag SHALL be accepted even in the first S_RUN cycle.
REQ-021 S_GAP SHALL last one cycle with all Stage_start low, then go to S_RUN with the next-higher enabled index, or to S_DONE if none remain.
REQ-022 S_DONE SHALL last one cycle with Done=1, then return to S_IDLE.
REQ-023 Stage_finished from non-active stages, and Trigger outside S_IDLE, SHALL be ignored.
REQ-024 SRAM bus SHALL be combinational: in S_RUN it passes the active stage's address, data and we_n; otherwise Idle_address, data 0, we_n 1.
REQ-025 Idle_enable SHALL be 1 only in S_IDLE; Busy SHALL be 1 in S_RUN, S_GAP and S_DONE.
REQ-026 Latency: Trigger at cycle t gives start at t+1; finished at t gives start low at t+1 and the next start, or Done, at t+2.

Reset
REQ-027 Reset=1 SHALL force S_IDLE, mask 0, Stage_start 0, Active_stage 0, Done 0, Timeout_error 0, watchdog 0, and Idle_enable 1 from the next edge.
REQ-028 Reset mid-sequence SHALL abandon the sequence without producing a Done pulse.

Configuration
REQ-029 Macro SRAM_SEQ_TIMEOUT_EN defined: the watchdog SHALL count S_RUN cycles of the current stage and clear on each stage entry. If it reaches TIMEOUT_CYCLES-1 without the finished flag, the sequencer SHALL set sticky Timeout_error, drop Stage_start, skip remaining stages and go to S_DONE. Timeout_error SHALL clear on the next accepted Trigger or Reset.
REQ-030 Macro undefined: no watchdog logic, Timeout_error tied 0, and S_RUN waits indefinitely.

Verification
REQ-031 Reset held 2 cycles -> Stage_start=0, Idle_enable=1, SRAM_we_n=1, SRAM_address=Idle_address, Done=0.
REQ-032 mask=3'b011, Trigger at t0; finished[0] at t0+5; finished[1] at t0+10 -> start[0] high t0+1..t0+5, start[1] high t0+7..t0+10, Done at t0+12, Idle_enable at t0+13.
REQ-033 mask=3'b101 -> stage 1 never started; during stage 2, Stage_address[2]=18'h23ABC and we_n=0 appear on SRAM_address/SRAM_we_n in the same cycle.
REQ-034 Trigger and finished[2] pulsed while stage 0 is active -> no state change, start[0] stays high.
REQ-035 SRAM_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, mask=3'b011, stage 0 silent -> Timeout_error=1 after 16 S_RUN cycles, Done next cycle, start[1] never asserted; macro undefined -> start[0] still high after 1000 cycles.
REQ-036 Reset at the 3rd cycle of stage 1 run -> S_IDLE next edge, no Done, Timeout_error=0.

Source files
------------

// File: rtl/sram_stage_sequencer.sv
// sram_stage_sequencer: grants a shared SRAM to up to eight client stages in
// ascending index order, one stage at a time, with a one-cycle gap between
// stages. When no stage owns the bus, the display-fetch address drives it.
// Optional watchdog: define SRAM_SEQ_TIMEOUT_EN to abort a stage that never
// reports completion within TIMEOUT_CYCLES run cycles.
module sram_stage_sequencer #(
   parameter int NUM_STAGES     = 3,
   parameter int ADDR_W         = 18,
   parameter int DATA_W         = 16,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                         Clock_50,
   input  logic                         Reset,
   input  logic                         Trigger,
   input  logic [NUM_STAGES-1:0]        Stage_mask,
   output logic [NUM_STAGES-1:0]        Stage_start,
   input  logic [NUM_STAGES-1:0]        Stage_finished,
   input  logic [NUM_STAGES*ADDR_W-1:0] Stage_address,
   input  logic [NUM_STAGES*DATA_W-1:0] Stage_write_data,
   input  logic [NUM_STAGES-1:0]        Stage_we_n,
   input  logic [ADDR_W-1:0]            Idle_address,
   output logic [ADDR_W-1:0]            SRAM_address,
   output logic [DATA_W-1:0]            SRAM_write_data,
   output logic                         SRAM_we_n,
   output logic                         Idle_enable,
   output logic                         Busy,
   output logic [2:0]                   Active_stage,
   output logic                         Done,
   output logic                         Timeout_error
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

   state_t                 state_q, state_n;
   logic [NUM_STAGES-1:0]  mask_q, mask_n;
   logic [2:0]             active_q, active_n;
   logic [NUM_STAGES-1:0]  act_onehot;
   logic                   act_finished;
   logic [ADDR_W-1:0]      sel_addr;
   logic [DATA_W-1:0]      sel_data;
   logic                   sel_we_n;
   logic                   wdog_expired;

   // Lowest set bit of a stage mask; remaining stages are always served in
   // ascending order, so this is also the next-higher enabled stage.
   function automatic logic [2:0] lowest_set(input logic [NUM_STAGES-1:0] m);
      logic [2:0] idx;
      idx = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (m[i]) idx = i[2:0];
      end
      return idx;
   endfunction

   // Decode the active stage into a one-hot select and pick its bus signals.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      act_onehot = '0;
      sel_addr   = '0;
      sel_data   = '0;
      sel_we_n   = 1'b1;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (active_q == i[2:0]) begin
            act_onehot[i] = 1'b1;
            sel_addr      = Stage_address[i*ADDR_W +: ADDR_W];
            sel_data      = Stage_write_data[i*DATA_W +: DATA_W];
            sel_we_n      = Stage_we_n[i];
         end
      end
   end

   assign act_finished = |(Stage_finished & act_onehot);

   // Next-state logic: accept a trigger, walk the latched mask, abort on watchdog.
   always_comb begin
      state_n  = state_q;
      mask_n   = mask_q;
      active_n = active_q;
      case (state_q)
         S_IDLE: begin
            if (Trigger && (|Stage_mask)) begin
               mask_n   = Stage_mask;
               active_n = lowest_set(Stage_mask);
               state_n  = S_RUN;
            end
         end
         S_RUN: begin
            if (act_finished) begin
               mask_n  = mask_q & ~act_onehot;
               state_n = S_GAP;
            end else if (wdog_expired) begin
               mask_n  = '0;
               state_n = S_DONE;
            end
         end
         S_GAP: begin
            if (|mask_q) begin
               active_n = lowest_set(mask_q);
               state_n  = S_RUN;
            end else begin
               state_n = S_DONE;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   // State, latched mask and active index registers.
   always_ff @(posedge Clock_50) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (Reset) begin
         state_q  <= S_IDLE;
         mask_q   <= '0;
         active_q <= '0;
      end else begin
         state_q  <= state_n;
         mask_q   <= mask_n;
         active_q <= active_n;
      end
   end

`ifdef SRAM_SEQ_TIMEOUT_EN
   logic [25:0] wdog_q;
   logic        tmo_q;

   assign wdog_expired = (wdog_q == 26'(TIMEOUT_CYCLES - 1));

   // Count run cycles of the current stage; zero outside S_RUN so each stage starts fresh.
   always_ff @(posedge Clock_50) begin
      if (Reset || (state_q != S_RUN)) wdog_q <= '0;
      else                             wdog_q <= wdog_q + 26'd1;
   end

   // Sticky timeout flag, cleared by reset or the next accepted trigger.
   always_ff @(posedge Clock_50) begin
      if (Reset)                                              tmo_q <= 1'b0;
      else if ((state_q == S_IDLE) && (state_n == S_RUN))     tmo_q <= 1'b0;
      else if ((state_q == S_RUN) && !act_finished && wdog_expired) tmo_q <= 1'b1;
   end

   assign Timeout_error = tmo_q;
`else
   assign wdog_expired  = 1'b0;
   assign Timeout_error = 1'b0;
`endif

   assign Stage_start     = (state_q == S_RUN) ? act_onehot : '0;
   assign SRAM_address    = (state_q == S_RUN) ? sel_addr : Idle_address;
   assign SRAM_write_data = (state_q == S_RUN) ? sel_data : '0;
   assign SRAM_we_n       = (state_q == S_RUN) ? sel_we_n : 1'b1;
   assign Idle_enable     = (state_q == S_IDLE);
   assign Busy            = (state_q != S_IDLE);
   assign Done            = (state_q == S_DONE);
   assign Active_stage    = active_q;

endmodule

// File: tb/tb_sram_stage_sequencer.sv
// Self-checking bench for sram_stage_sequencer. Each scenario pushes the
// expected per-cycle bus/handshake picture into a scoreboard queue as it
// drives stimulus and pops it when the DUT outputs are sampled mid-cycle.
module tb_sram_stage_sequencer;

   localparam logic [17:0] IDLE_ADDR = 18'h12345;

   typedef enum {E_IDLE, E_RUN, E_GAP, E_DONE} ph_t;

   typedef struct packed {
      logic        done;
      logic        idle;
      logic        busy;
      logic        tmo;
      logic [2:0]  start;
      logic [17:0] addr;
      logic [15:0] data;
      logic        we_n;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        trigger;
   logic [2:0]  mask;
   logic [2:0]  start;
   logic [2:0]  finished;
   logic [53:0] st_addr;
   logic [47:0] st_data;
   logic [2:0]  st_we_n;
   logic [17:0] idle_addr;
   logic [17:0] sram_addr;
   logic [15:0] sram_data;
   logic        sram_we_n;
   logic        idle_en;
   logic        busy;
   logic [2:0]  act;
   logic        done;
   logic        tmo;

   logic [17:0] addr_tab [3] = '{18'h00111, 18'h00222, 18'h23ABC};
   logic [15:0] data_tab [3] = '{16'hA000, 16'hB001, 16'hC002};
   logic        we_tab   [3] = '{1'b1, 1'b1, 1'b0};

   obs_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   sram_stage_sequencer #(
      .NUM_STAGES(3), .ADDR_W(18), .DATA_W(16), .TIMEOUT_CYCLES(16)
   ) dut (
      .Clock_50(clk), .Reset(rst), .Trigger(trigger), .Stage_mask(mask),
      .Stage_start(start), .Stage_finished(finished), .Stage_address(st_addr),
      .Stage_write_data(st_data), .Stage_we_n(st_we_n), .Idle_address(idle_addr),
      .SRAM_address(sram_addr), .SRAM_write_data(sram_data), .SRAM_we_n(sram_we_n),
      .Idle_enable(idle_en), .Busy(busy), .Active_stage(act), .Done(done),
      .Timeout_error(tmo)
   );

   // Expected outputs for a given phase, derived from the bus/handshake rules.
   function automatic obs_t exp_of(ph_t ph, int s, logic t);
      obs_t o;
      o.done  = (ph == E_DONE);
      o.idle  = (ph == E_IDLE);
      o.busy  = (ph != E_IDLE);
      o.tmo   = t;
      o.start = 3'b000;
      o.addr  = IDLE_ADDR;
      o.data  = 16'h0000;
      o.we_n  = 1'b1;
      if (ph == E_RUN) begin
         o.start = 3'(1 << s);
         o.addr  = addr_tab[s];
         o.data  = data_tab[s];
         o.we_n  = we_tab[s];
      end
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = {done, idle_en, busy, tmo, start, sram_addr, sram_data, sram_we_n};
      return o;
   endfunction

   task automatic test_reset();
      obs_t got, e;
      for (int k = 0; k < 3; k++) begin
         rst = (k < 2);
         sb.push_back(exp_of(E_IDLE, 0, 1'b0));
         @(negedge clk);
         got = sample();
         e   = sb.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL reset cycle %0d: got %h expected %h", k, got, e);
         end
         n_cmp++;
         if (act !== 3'd0) begin
            n_err++;
            $display("FAIL reset_active_stage cycle %0d: got %0d expected 0", k, act);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_two_stage();
      obs_t got, e;
      ph_t  ph;
      for (int k = 0; k <= 13; k++) begin
         trigger  = (k == 0);
         mask     = 3'b011;
         finished = (k == 5) ? 3'b001 : (k == 10) ? 3'b010 : 3'b000;
         if (k == 0 || k == 13)      ph = E_IDLE;
         else if (k == 6 || k == 11) ph = E_GAP;
         else if (k == 12)           ph = E_DONE;
         else                        ph = E_RUN;
         sb.push_back(exp_of(ph, (k <= 5) ? 0 : 1, 1'b0));
         @(negedge clk);
         got = sample();
         e   = sb.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL two_stage cycle %0d: got %h expected %h", k, got, e);
         end
         @(posedge clk); #1;
      end
      trigger = 1'b0; finished = 3'b000;
   endtask

   task automatic test_skip_mask();
      obs_t got, e;
      ph_t  ph;
      for (int k = 0; k <= 9; k++) begin
         trigger  = (k == 0);
         mask     = 3'b101;
         finished = (k == 2) ? 3'b001 : (k == 6) ? 3'b100 : 3'b000;
         if (k == 0 || k == 9)      ph = E_IDLE;
         else if (k == 3 || k == 7) ph = E_GAP;
         else if (k == 8)           ph = E_DONE;
         else                       ph = E_RUN;
         sb.push_back(exp_of(ph, (k <= 2) ? 0 : 2, 1'b0));
         @(negedge clk);
         got = sample();
         e   = sb.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL skip_mask cycle %0d: got %h expected %h", k, got, e);
         end
         @(posedge clk); #1;
      end
      trigger = 1'b0; finished = 3'b000;
   endtask

   task automatic test_ignore();
      obs_t got, e;
      ph_t  ph;
      for (int k = 0; k <= 8; k++) begin
         trigger  = (k <= 1) || (k == 3);
         mask     = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : 3'b110;
         finished = (k == 3) ? 3'b110 : (k == 5) ? 3'b001 : 3'b000;
         if (k <= 1 || k == 8) ph = E_IDLE;
         else if (k == 6)      ph = E_GAP;
         else if (k == 7)      ph = E_DONE;
         else                  ph = E_RUN;
         sb.push_back(exp_of(ph, 0, 1'b0));
         @(negedge clk);
         got = sample();
         e   = sb.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL ignore cycle %0d: got %h expected %h", k, got, e);
         end
         if (k == 4) begin
            n_cmp++;
            if (act !== 3'd0) begin
               n_err++;
               $display("FAIL ignore_active_stage: got %0d expected 0", act);
            end
         end
         @(posedge clk); #1;
      end
      trigger = 1'b0; finished = 3'b000;
   endtask

   task automatic test_back_to_back();
      obs_t got, e;
      ph_t  ph;
      for (int k = 0; k <= 8; k++) begin
         trigger  = (k == 0) || (k == 3) || (k == 4);
         mask     = (k == 0) ? 3'b100 : 3'b001;
         finished = (k == 1) ? 3'b100 : (k == 5) ? 3'b001 : 3'b000;
         if (k == 0 || k == 4 || k == 8) ph = E_IDLE;
         else if (k == 2 || k == 6)      ph = E_GAP;
         else if (k == 3 || k == 7)      ph = E_DONE;
         else                            ph = E_RUN;
         sb.push_back(exp_of(ph, (k == 1) ? 2 : 0, 1'b0));
         @(negedge clk);
         got = sample();
         e   = sb.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL back_to_back cycle %0d: got %h expected %h", k, got, e);
         end
         @(posedge clk); #1;
      end
      trigger = 1'b0; finished = 3'b000;
   endtask

`ifdef SRAM_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      obs_t got, e;
      ph_t  ph;
      logic t;
      for (int k = 0; k <= 22; k++) begin
         trigger  = (k == 0) || (k == 18);
         mask     = (k == 0) ? 3'b011 : 3'b001;
         finished = (k == 19) ? 3'b001 : 3'b000;
         if (k == 0 || k == 18 || k == 22) ph = E_IDLE;
         else if (k == 17 || k == 21)      ph = E_DONE;
         else if (k == 20)                 ph = E_GAP;
         else                              ph = E_RUN;
         t = (k == 17) || (k == 18);
         sb.push_back(exp_of(ph, 0, t));
         @(negedge clk);
         got = sample();
         e   = sb.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL timeout cycle %0d: got %h expected %h", k, got, e);
         end
         @(posedge clk); #1;
      end
      trigger = 1'b0; finished = 3'b000;
   endtask
`else
   task automatic test_timeout();
      obs_t got, e;
      for (int k = 0; k <= 1002; k++) begin
         trigger = (k == 0);
         mask    = 3'b001;
         rst     = (k == 1001);
         sb.push_back(exp_of((k == 0 || k == 1002) ? E_IDLE : E_RUN, 0, 1'b0));
         @(negedge clk);
         got = sample();
         e   = sb.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL no_watchdog cycle %0d: got %h expected %h", k, got, e);
         end
         @(posedge clk); #1;
      end
      trigger = 1'b0; rst = 1'b0;
   endtask
`endif

   task automatic test_reset_mid();
      obs_t got, e;
      ph_t  ph;
      for (int k = 0; k <= 8; k++) begin
         trigger  = (k == 0);
         mask     = 3'b011;
         finished = (k == 1) ? 3'b001 : 3'b000;
         rst      = (k == 5);
         if (k == 0 || k >= 6) ph = E_IDLE;
         else if (k == 2)      ph = E_GAP;
         else                  ph = E_RUN;
         sb.push_back(exp_of(ph, (k == 1) ? 0 : 1, 1'b0));
         @(negedge clk);
         got = sample();
         e   = sb.pop_front();
         n_cmp++;
         if (got !== e) begin
            n_err++;
            $display("FAIL reset_mid cycle %0d: got %h expected %h", k, got, e);
         end
         @(posedge clk); #1;
      end
      trigger = 1'b0; finished = 3'b000; rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      trigger   = 1'b0;
      mask      = 3'b000;
      finished  = 3'b000;
      st_addr   = {addr_tab[2], addr_tab[1], addr_tab[0]};
      st_data   = {data_tab[2], data_tab[1], data_tab[0]};
      st_we_n   = {we_tab[2], we_tab[1], we_tab[0]};
      idle_addr = IDLE_ADDR;
      test_reset();
      test_two_stage();
      test_skip_mask();
      test_ignore();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
